page_ram_arbiter: RTL and testbench

//  Shares one inferred single-port page RAM (DEPTH x DW) between two requesters.

---
 rtl/page_ram_pkg.sv | 16 +
 rtl/ram_sp_infer.sv | 33 +++
 rtl/page_ram_arbiter.sv | 116 +++++++++++
 tb/tb_page_ram_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/page_ram_pkg.sv
// Shared types and default parameters for the page RAM arbiter slice.
// Holds the FSM state encoding and the requester identifier type.
package page_ram_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  localparam int         DW_DEF       = 8;
  localparam int         AW_DEF       = 8;
  localparam logic [7:0] INIT_VAL_DEF = 8'h00;

endpackage

// File: rtl/ram_sp_infer.sv
// Single-port RAM, registered read, write-first, no reset on the array.
// The read register updates only when en is high, so it holds between accesses.
module ram_sp_infer #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          hw_clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_data_reg;

  always_ff @(posedge hw_clk) begin
    if (en) begin
      if (we) begin
        mem[addr]   <= wdata;
        rd_data_reg <= wdata;
      end else begin
        rd_data_reg <= mem[addr];
      end
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/page_ram_arbiter.sv
// Round-robin arbiter sharing one page RAM between two requesters.
// A clear sequencer fills the RAM with INIT_VAL after reset or on clear_req.
module page_ram_arbiter
  import page_ram_pkg::*;
#(
  parameter int            DW       = DW_DEF,
  parameter int            AW       = AW_DEF,
  parameter logic [DW-1:0] INIT_VAL = DW'(INIT_VAL_DEF)
) (
  input  logic          hw_clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          busy,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] rd_data
);

  arb_state_t    state_reg, state_next;
  logic [AW-1:0] clr_addr_reg, clr_addr_next;
  port_id_t      last_gnt_reg, last_gnt_next;
  logic          rvalid0_reg, rvalid0_next;
  logic          rvalid1_reg, rvalid1_next;
  logic          gnt0, gnt1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
      last_gnt_reg <= PORT1;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      last_gnt_reg <= last_gnt_next;
      rvalid0_reg  <= rvalid0_next;
      rvalid1_reg  <= rvalid1_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    last_gnt_next = last_gnt_reg;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = clr_addr_reg;
    ram_wdata     = INIT_VAL;
    case (state_reg)
      ST_CLEAR: begin
        ram_en        = 1'b1;
        ram_we        = 1'b1;
        clr_addr_next = clr_addr_reg + AW'(1);
        if (&clr_addr_reg) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        // A clear request pre-empts any access in the same cycle.
        if (clear_req) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end else begin
          gnt0 = p0_req && (!p1_req || last_gnt_reg == PORT1);
          gnt1 = p1_req && (!p0_req || last_gnt_reg == PORT0);
          if (gnt0) begin
            ram_en        = 1'b1;
            ram_we        = p0_we;
            ram_addr      = p0_addr;
            ram_wdata     = p0_wdata;
            last_gnt_next = PORT0;
          end else if (gnt1) begin
            ram_en        = 1'b1;
            ram_we        = p1_we;
            ram_addr      = p1_addr;
            ram_wdata     = p1_wdata;
            last_gnt_next = PORT1;
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
    rvalid0_next = gnt0 && !p0_we;
    rvalid1_next = gnt1 && !p1_we;
  end

  ram_sp_infer #(.DW(DW), .AW(AW)) u_ram (
    .hw_clk  (hw_clk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rd_data (rd_data)
  );

  assign busy      = (state_reg == ST_CLEAR);
  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = rvalid0_reg;
  assign p1_rvalid = rvalid1_reg;

endmodule

// File: tb/tb_page_ram_arbiter.sv
// Bench for page_ram_arbiter: table-driven cycles with a read-data scoreboard,
// plus hand-written sequences for clear, reset release and mid-read reset.
module tb_page_ram_arbiter;

  logic       hw_clk = 1'b0;
  logic       rst_n;
  logic       clear_req;
  logic       busy;
  logic       p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [7:0] p0_addr, p0_wdata;
  logic       p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [7:0] p1_addr, p1_wdata;
  logic [7:0] rd_data;

  always #5 hw_clk = ~hw_clk;

  page_ram_arbiter dut (
    .hw_clk    (hw_clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .rd_data   (rd_data)
  );

  typedef struct {
    logic       clr;
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    logic       g0, g1;
  } vec_t;

  typedef struct {
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [0:255];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(input logic clr,
                              input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                              input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.clr = clr;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // Pop the expectation left by last cycle's grant (if any) and compare.
  task automatic check_rv();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid0", p0_rvalid, (e.port == 1'b0));
      chk("rvalid1", p1_rvalid, (e.port == 1'b1));
      chk("rd_data", rd_data, e.data);
    end else begin
      chk("rvalid0_idle", p0_rvalid, 1'b0);
      chk("rvalid1_idle", p1_rvalid, 1'b0);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge hw_clk);
    clear_req = v.clr;
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    #1;
    check_rv();
    chk("gnt0", p0_gnt, v.g0);
    chk("gnt1", p1_gnt, v.g1);
    $display("[TB] t=%0t clr=%0b p0 req=%0b we=%0b @%02h d=%02h | p1 req=%0b we=%0b @%02h d=%02h | gnt=%0b%0b",
             $time, v.clr, v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1, p0_gnt, p1_gnt);
    if (v.g0) begin
      if (v.w0) model[v.a0] = v.d0;
      else sb.push_back('{1'b0, model[v.a0]});
    end
    if (v.g1) begin
      if (v.w1) model[v.a1] = v.d1;
      else sb.push_back('{1'b1, model[v.a1]});
    end
    if (v.clr) model_clear();
  endtask

  // Counts cycles with busy high, starting at the current sample point.
  task automatic count_busy(output int n, output bit act_seen);
    n = 0;
    act_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) return;
      n++;
      if (p0_gnt || p1_gnt || p0_rvalid || p1_rvalid) act_seen = 1'b1;
      @(negedge hw_clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
  endtask

  vec_t vec_a [15];
  vec_t vec_b [4];
  vec_t vec_c [2];
  int   nb;
  bit   seen;

  initial begin
    //              clr r0 w0 a0     d0     r1 w1 a1     d1     g0 g1
    vec_a[0]  = mk(0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
    vec_a[1]  = mk(0, 1, 1, 8'h03, 8'h0E, 0, 0, 8'h00, 8'h00, 1, 0);
    vec_a[2]  = mk(0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
    vec_a[3]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    vec_a[4]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5C, 0, 1);
    vec_a[5]  = mk(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0);
    vec_a[6]  = mk(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1);
    vec_a[7]  = mk(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0);
    vec_a[8]  = mk(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1);
    vec_a[9]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'hA5, 0, 1);
    vec_a[10] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 1);
    vec_a[11] = mk(0, 1, 1, 8'h00, 8'h77, 1, 0, 8'h10, 8'h00, 1, 0);
    vec_a[12] = mk(0, 1, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1);
    vec_a[13] = mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
    vec_a[14] = mk(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

    vec_b[0]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 1);
    vec_b[1]  = mk(0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
    vec_b[2]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1);
    vec_b[3]  = mk(0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);

    vec_c[0]  = mk(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'hFF, 8'h00, 1, 0);
    vec_c[1]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

    // Reset state and first clear sequence
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (3) @(negedge hw_clk);
    #1;
    chk("reset_busy", busy, 1'b1);
    chk("reset_gnt", {p0_gnt, p1_gnt}, 2'b00);
    chk("reset_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    @(negedge hw_clk);
    rst_n = 1'b1;
    #1;
    count_busy(nb, seen);
    chk("init_clear_cycles", nb, 256);
    chk("init_clear_quiet", seen, 1'b0);

    // Write/read, contention, RAW at 0xFF, read-before-clear, clear_req
    foreach (vec_a[i]) step(vec_a[i]);

    @(negedge hw_clk);
    clear_req = 1'b0;
    #1;
    count_busy(nb, seen);
    chk("clear_req_cycles", nb, 256);
    chk("clear_req_quiet", seen, 1'b0);
    chk("first_idle_gnt0", p0_gnt, 1'b1);
    $display("[TB] t=%0t first idle cycle after clear: p0 read @00 gnt=%0b%0b", $time, p0_gnt, p1_gnt);
    sb.push_back('{1'b0, model[8'h00]});

    foreach (vec_b[i]) step(vec_b[i]);

    // Mid-read reset: the pending rvalid is killed and a full clear runs
    @(posedge hw_clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    sb.delete();
    model_clear();
    #1;
    chk("midreset_rvalid0", p0_rvalid, 1'b0);
    @(negedge hw_clk);
    #1;
    chk("midreset_rvalid0_later", p0_rvalid, 1'b0);
    chk("midreset_busy", busy, 1'b1);
    @(negedge hw_clk);
    rst_n = 1'b1;
    #1;
    count_busy(nb, seen);
    chk("reclear_cycles", nb, 256);
    chk("reclear_quiet", seen, 1'b0);

    // Round-robin pointer is back to favouring port 0
    foreach (vec_c[i]) step(vec_c[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
